keycode_motion: RTL and testbench

Sits between the NIOS SoC's keycode PIO export and the ball motion stage, in the 50 MHz system clock domain. Qualifies the raw 8-bit USB HID keycode: it must stay stable for a programmable time before it is committed. W/A/S/D presses are latched into a persistent direction register, and edge-bounce requests from the ball stage can flip that direction. Once per frame it emits a signed per-frame motion vector for the ball stage to add to its position.

---
 rtl/keycode_motion.sv | 145 ++++++++++++++
 tb/tb_keycode_motion.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/keycode_motion.sv
// Keycode qualifier and direction latch feeding the ball motion stage.
// Emits one signed per-frame step vector after every frame strobe.
module keycode_motion #(
  parameter int         STABLE_CYCLES = 1000,
  parameter int         STEP          = 1,
  parameter logic [7:0] KEY_UP        = 8'h1A,
  parameter logic [7:0] KEY_LEFT      = 8'h04,
  parameter logic [7:0] KEY_DOWN      = 8'h16,
  parameter logic [7:0] KEY_RIGHT     = 8'h07
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_stb,
  input  logic       reverse_x,
  input  logic       reverse_y,
  output logic [9:0] motion_x,
  output logic [9:0] motion_y,
  output logic       motion_valid,
  output logic       key_event,
  output logic [7:0] active_key,
  output logic [2:0] dir,
  output logic [7:0] press_count
);
  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  localparam logic [2:0] D_NONE  = 3'd0;
  localparam logic [2:0] D_UP    = 3'd1;
  localparam logic [2:0] D_DOWN  = 3'd2;
  localparam logic [2:0] D_LEFT  = 3'd3;
  localparam logic [2:0] D_RIGHT = 3'd4;

  typedef enum logic [1:0] {IDLE, DIR_HELD, OTHER_HELD} state_t;

  state_t        r_state;
  logic [7:0]    r_cand;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_active;
  logic [7:0]    r_press;
  logic [2:0]    r_dir;
  logic          r_key_event;
  logic          r_pend;
  logic          r_mv;
  logic [9:0]    r_mx;
  logic [9:0]    r_my;

  logic       w_commit;
  logic       w_is_dir;
  logic [2:0] w_key_dir;
  state_t     w_nxt;
  logic [9:0] w_step;
  logic [9:0] w_nstep;

  assign w_step  = 10'(STEP);
  assign w_nstep = -w_step;

  // A commit needs the full stable run and a key different from the one held.
  assign w_commit = (keycode == r_cand) && (r_cnt == CNT_MAX) && (r_cand != r_active);

  always_comb begin
    w_key_dir = D_NONE;
    w_is_dir  = 1'b1;
    case (r_cand)
      KEY_UP:    w_key_dir = D_UP;
      KEY_DOWN:  w_key_dir = D_DOWN;
      KEY_LEFT:  w_key_dir = D_LEFT;
      KEY_RIGHT: w_key_dir = D_RIGHT;
      default:   w_is_dir  = 1'b0;
    endcase
    if (r_cand == 8'h00)  w_nxt = IDLE;
    else if (w_is_dir)    w_nxt = DIR_HELD;
    else                  w_nxt = OTHER_HELD;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_active    <= '0;
      r_press     <= '0;
      r_dir       <= D_NONE;
      r_key_event <= 1'b0;
      r_pend      <= 1'b0;
      r_mv        <= 1'b0;
      r_mx        <= '0;
      r_my        <= '0;
    end else begin
      if (keycode != r_cand) begin
        r_cand <= keycode;
        r_cnt  <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end

      r_key_event <= w_commit;
      if (w_commit) begin
        r_active <= r_cand;
        if (r_cand != 8'h00) r_press <= r_press + 8'd1;
      end

      case (r_state)
        IDLE, DIR_HELD, OTHER_HELD: if (w_commit) r_state <= w_nxt;
        default: r_state <= IDLE;
      endcase

      // A commit on the same edge as a bounce request takes priority.
      if (w_commit) begin
        if (w_is_dir) r_dir <= w_key_dir;
      end else begin
        case (r_dir)
          D_LEFT:  if (reverse_x) r_dir <= D_RIGHT;
          D_RIGHT: if (reverse_x) r_dir <= D_LEFT;
          D_UP:    if (reverse_y) r_dir <= D_DOWN;
          D_DOWN:  if (reverse_y) r_dir <= D_UP;
          default: ;
        endcase
      end

      // Motion is sampled one edge after the strobe so it sees that edge's dir update.
      r_pend <= frame_stb;
      r_mv   <= r_pend;
      if (r_pend) begin
        r_mx <= '0;
        r_my <= '0;
        case (r_dir)
          D_UP:    r_my <= w_nstep;
          D_DOWN:  r_my <= w_step;
          D_LEFT:  r_mx <= w_nstep;
          D_RIGHT: r_mx <= w_step;
          default: ;
        endcase
      end
    end
  end

  assign motion_x     = r_mx;
  assign motion_y     = r_my;
  assign motion_valid = r_mv;
  assign key_event    = r_key_event;
  assign active_key   = r_active;
  assign dir          = r_dir;
  assign press_count  = r_press;
endmodule

// File: tb/tb_keycode_motion.sv
// Directed bench for keycode_motion: per-cycle vector table plus reset,
// wrap and mid-qualification reset sequences (STABLE_CYCLES=4, STEP=1).
module tb_keycode_motion;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_stb = 1'b0, reverse_x = 1'b0, reverse_y = 1'b0;
  logic [9:0] motion_x, motion_y;
  logic       motion_valid, key_event;
  logic [7:0] active_key, press_count;
  logic [2:0] dir;

  int n_cmp = 0;
  int n_bad = 0;

  keycode_motion #(.STABLE_CYCLES(4), .STEP(1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_stb(frame_stb),
    .reverse_x(reverse_x), .reverse_y(reverse_y), .motion_x(motion_x),
    .motion_y(motion_y), .motion_valid(motion_valid), .key_event(key_event),
    .active_key(active_key), .dir(dir), .press_count(press_count)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic [7:0] kc;
    logic       fs, rx, ry;
    logic       ke;
    logic [2:0] dir;
    logic [7:0] ak, pc;
    logic       mv;
    logic [9:0] mx, my;
  } vec_t;

  vec_t tbl[$];
  vec_t last;

  task automatic add(input logic [7:0] kc, input logic fs, rx, ry, ke,
                     input logic [2:0] d, input logic [7:0] ak, pc,
                     input logic mv, input logic [9:0] mx, my);
    vec_t v;
    v.kc = kc; v.fs = fs; v.rx = rx; v.ry = ry; v.ke = ke; v.dir = d;
    v.ak = ak; v.pc = pc; v.mv = mv; v.mx = mx; v.my = my;
    tbl.push_back(v);
    last = v;
  endtask

  // Quiet cycles: inputs fixed, outputs hold, no pulses.
  task automatic hold(input logic [7:0] kc, input int n);
    for (int i = 0; i < n; i++)
      add(kc, 1'b0, 1'b0, 1'b0, 1'b0, last.dir, last.ak, last.pc, 1'b0, last.mx, last.my);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    Reset_n = 1'b0;
    repeat (n) step();
    Reset_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ke"}, key_event, 0);
    chk({nm, ".dir"}, dir, 0);
    chk({nm, ".ak"}, active_key, 0);
    chk({nm, ".pc"}, press_count, 0);
    chk({nm, ".mv"}, motion_valid, 0);
    chk({nm, ".mx"}, motion_x, 0);
    chk({nm, ".my"}, motion_y, 0);
  endtask

  initial begin
    int nke;

    // Reset with a direction key already on the bus.
    keycode = 8'h07;
    do_reset(3);
    chk_zero("rst");
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("rst_rel.e%0d.ke", e), key_event, 0);
    end
    step();
    chk("rst_rel.e5.ke", key_event, 1);
    chk("rst_rel.e5.dir", dir, 4);
    chk("rst_rel.e5.ak", active_key, 8'h07);
    chk("rst_rel.e5.pc", press_count, 1);

    // Per-cycle vector table.
    keycode = 8'h00;
    do_reset(2);
    last = '{kc: 8'h00, fs: 0, rx: 0, ry: 0, ke: 0, dir: 0, ak: 0, pc: 0, mv: 0, mx: 0, my: 0};
    hold(8'h1A, 3); hold(8'h00, 1); hold(8'h1A, 4);
    add(8'h1A, 0, 0, 0, 1, 1, 8'h1A, 1, 0, 10'h000, 10'h000);
    add(8'h1A, 1, 0, 0, 0, 1, 8'h1A, 1, 0, 10'h000, 10'h000);
    add(8'h1A, 0, 0, 0, 0, 1, 8'h1A, 1, 1, 10'h000, 10'h3FF);
    hold(8'h1A, 1);
    hold(8'h07, 4);
    add(8'h07, 0, 0, 0, 1, 4, 8'h07, 2, 0, 10'h000, 10'h3FF);
    hold(8'h00, 4);
    add(8'h00, 0, 0, 0, 1, 4, 8'h00, 2, 0, 10'h000, 10'h3FF);
    add(8'h00, 1, 0, 0, 0, 4, 8'h00, 2, 0, 10'h000, 10'h3FF);
    add(8'h00, 0, 0, 0, 0, 4, 8'h00, 2, 1, 10'h001, 10'h000);
    add(8'h00, 0, 1, 0, 0, 3, 8'h00, 2, 0, 10'h001, 10'h000);
    add(8'h00, 1, 0, 0, 0, 3, 8'h00, 2, 0, 10'h001, 10'h000);
    add(8'h00, 0, 0, 0, 0, 3, 8'h00, 2, 1, 10'h3FF, 10'h000);
    add(8'h00, 0, 0, 1, 0, 3, 8'h00, 2, 0, 10'h3FF, 10'h000);
    add(8'h00, 0, 1, 1, 0, 4, 8'h00, 2, 0, 10'h3FF, 10'h000);
    add(8'h00, 1, 1, 0, 0, 3, 8'h00, 2, 0, 10'h3FF, 10'h000);
    add(8'h00, 1, 0, 0, 0, 3, 8'h00, 2, 1, 10'h3FF, 10'h000);
    add(8'h00, 0, 0, 0, 0, 3, 8'h00, 2, 1, 10'h3FF, 10'h000);
    hold(8'h00, 1);
    hold(8'h1A, 4);
    add(8'h1A, 0, 0, 0, 1, 1, 8'h1A, 3, 0, 10'h3FF, 10'h000);
    hold(8'h16, 4);
    add(8'h16, 0, 0, 1, 1, 2, 8'h16, 4, 0, 10'h3FF, 10'h000);
    hold(8'h16, 1);
    add(8'h16, 0, 0, 1, 0, 1, 8'h16, 4, 0, 10'h3FF, 10'h000);
    add(8'h16, 1, 1, 0, 0, 1, 8'h16, 4, 0, 10'h3FF, 10'h000);
    add(8'h16, 0, 0, 0, 0, 1, 8'h16, 4, 1, 10'h000, 10'h3FF);
    hold(8'h05, 4);
    add(8'h05, 0, 0, 0, 1, 1, 8'h05, 5, 0, 10'h000, 10'h3FF);
    hold(8'h05, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      keycode = tbl[i].kc; frame_stb = tbl[i].fs;
      reverse_x = tbl[i].rx; reverse_y = tbl[i].ry;
      step();
      chk($sformatf("v%0d.ke", i), key_event, tbl[i].ke);
      chk($sformatf("v%0d.dir", i), dir, tbl[i].dir);
      chk($sformatf("v%0d.ak", i), active_key, tbl[i].ak);
      chk($sformatf("v%0d.pc", i), press_count, tbl[i].pc);
      chk($sformatf("v%0d.mv", i), motion_valid, tbl[i].mv);
      chk($sformatf("v%0d.mx", i), motion_x, tbl[i].mx);
      chk($sformatf("v%0d.my", i), motion_y, tbl[i].my);
    end
    frame_stb = 0; reverse_x = 0; reverse_y = 0;

    // 256 alternating A / release commits: 128 nonzero presses.
    keycode = 8'h00;
    do_reset(2);
    nke = 0;
    for (int i = 0; i < 256; i++) begin
      keycode = (i % 2 == 0) ? 8'h04 : 8'h00;
      repeat (5) begin
        step();
        if (key_event) nke++;
      end
    end
    chk("wrap.events", nke, 256);
    chk("wrap.pc", press_count, 8'h80);
    chk("wrap.ak", active_key, 8'h00);
    chk("wrap.dir", dir, 3);

    // Reset lands while a new key is two counts into qualification.
    keycode = 8'h1A;
    repeat (3) step();
    chk("midq.pre.ke", key_event, 0);
    do_reset(1);
    chk_zero("midq.rst");
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("midq.e%0d.ke", e), key_event, 0);
    end
    step();
    chk("midq.e5.ke", key_event, 1);
    chk("midq.e5.dir", dir, 1);
    chk("midq.e5.pc", press_count, 1);
    step();
    chk("midq.e6.ke", key_event, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
